retire_trace_packer: RTL and testbench

Synthesizable retirement-trace capture block sitting directly downstream of the MEM/WB pipeline register, beside the simulation-only JSON trace logger. Each cycle a valid instruction retires from WB, the block captures cycle count, PC, destination register and write-back data into a small FIFO. It then serializes each record into a fixed 14-byte packet on a byte-wide valid/ready stream for an off-chip trace port (UART or debug FIFO). Overflow is reported, never back-pressured into the core.

---
 rtl/retire_trace_packer.sv | 138 +++++++++++++
 tb/tb_retire_trace_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_packer.sv
// Retirement trace capture: queues {cycle, pc, rd, data} records from WB and serializes each
// into a 14-byte little-endian packet on a byte-wide valid/ready stream. Drops on overflow.
module retire_trace_packer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   cycle_count,
  input  logic                          retire_valid,
  input  logic [31:0]                   retire_pc,
  input  logic [4:0]                    retire_rd,
  input  logic                          retire_reg_write,
  input  logic [31:0]                   retire_data,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned RecW = 102;
  localparam int unsigned PktW = 112;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam logic [3:0]      LastIdx  = 4'd13;
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(FIFO_DEPTH);

  // Record layout: {cycle[101:70], pc[69:38], data[37:6], rd[5:1], we[0]}
  logic [RecW-1:0] mem_q [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [0:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [PktW-1:0] pkt_q, pkt_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            cap_we;
  logic [RecW-1:0] cap_rec;
  logic            capture, full, push, drop, hs, last_hs, pop;

  function automatic logic [PktW-1:0] build_pkt(input logic [RecW-1:0] r);
    logic [7:0] hdr;
    hdr = {r[0], 2'b00, r[5:1]};
    return {r[37:6], r[69:38], r[101:70], hdr, 8'hA5};
  endfunction

  always_comb begin
    cap_we  = retire_reg_write && (retire_rd != 5'd0);
    cap_rec = {cycle_count, retire_pc, (cap_we ? retire_data : 32'd0), retire_rd, cap_we};
    capture = enable && retire_valid;
    // Space is judged on the pre-edge level; a same-cycle pop does not make room.
    full    = (level_q == DepthLvl);
    push    = capture && !full;
    drop    = capture && full;
    hs      = (state_q == StSend) && out_ready;
    last_hs = hs && (idx_q == LastIdx);
    pop     = (level_q != '0) && ((state_q == StIdle) || last_hs);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    if (hs) begin
      pkt_d = {8'h00, pkt_q[PktW-1:8]};
      idx_d = idx_q + 4'd1;
      if (idx_q == LastIdx) begin
        state_d = StIdle;
        idx_d   = 4'd0;
      end
    end
    // Loading the next record on the last handshake keeps packets back-to-back.
    if (pop) begin
      state_d = StSend;
      idx_d   = 4'd0;
      pkt_d   = build_pkt(mem_q[rd_ptr_q]);
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d    = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      pkt_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the level counter gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cap_rec;
    end
  end

  assign out_valid  = (state_q == StSend);
  assign out_data   = pkt_q[7:0];
  assign fifo_level = level_q;
  assign busy       = (state_q == StSend) || (level_q != '0);
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_packer.sv
// Directed + randomized bench for retire_trace_packer against a queue-based packet model.
module tb_retire_trace_packer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, enable, retire_valid, retire_reg_write, out_ready;
  logic [31:0]   cycle_count, retire_pc, retire_data;
  logic [4:0]    retire_rd;
  logic          out_valid, busy, overflow;
  logic [7:0]    out_data;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_count;

  retire_trace_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .cycle_count      (cycle_count),
    .retire_valid     (retire_valid),
    .retire_pc        (retire_pc),
    .retire_rd        (retire_rd),
    .retire_reg_write (retire_reg_write),
    .retire_data      (retire_data),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .fifo_level       (fifo_level),
    .busy             (busy),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
  } rec_t;

  // Model: records waiting in the FIFO, bytes left of the packet on the wire,
  // and the full expected byte stream with the index of the byte now presented.
  rec_t       mq[$];
  int         rem;
  logic [7:0] exp_q[$];
  int         sidx;
  bit         m_ovf;
  int         m_drops;
  logic [7:0] got[$];
  int         n_pass = 0;
  int         n_total = 0;
  rec_t       zero_rec = '{cyc: 32'd0, pc: 32'd0, data: 32'd0, rd: 5'd0, wr: 1'b0};

  localparam logic [7:0] GOLD [14] = '{8'hA5, 8'h85, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04,
                                       8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic rec_t mk(input logic [31:0] c, input logic [31:0] p, input logic [4:0] rd,
                              input logic wr, input logic [31:0] d);
    rec_t r;
    r.cyc = c; r.pc = p; r.rd = rd; r.wr = wr; r.data = d;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    return mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
  endfunction

  function automatic void add_pkt(input rec_t r);
    logic        we;
    logic [31:0] d;
    we = r.wr && (r.rd != 5'd0);
    d  = we ? r.data : 32'd0;
    exp_q.push_back(8'hA5);
    exp_q.push_back({we, 2'b00, r.rd});
    for (int i = 0; i < 4; i++) exp_q.push_back(r.cyc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(r.pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
  endfunction

  task automatic model_step(input bit cap, input rec_t r, input bit rdy);
    int lvl;
    bit hs, pop;
    lvl = mq.size();
    hs  = (rem > 0) && rdy;
    pop = (lvl > 0) && ((rem == 0) || ((rem == 1) && hs));
    if (hs) begin
      rem--;
      sidx++;
    end
    if (pop) begin
      void'(mq.pop_front());
      rem = 14;
    end
    if (cap) begin
      if (lvl < int'(DEPTH)) begin
        mq.push_back(r);
        add_pkt(r);
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    rem = 0; sidx = 0; m_ovf = 1'b0; m_drops = 0;
  endtask

  task automatic check_state();
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(rem > 0));
    chk("busy", 32'(busy), 32'((rem > 0) || (mq.size() > 0)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    if (rem > 0) chk("byte", 32'(out_data), 32'(exp_q[sidx]));
  endtask

  // Inputs are applied 1 time unit after an edge; outputs sampled 1 unit after the next edge.
  task automatic cyc(input bit en, input bit rv, input rec_t r, input bit rdy);
    bit         stall;
    logic [7:0] held;
    enable = en; retire_valid = rv; out_ready = rdy;
    cycle_count = r.cyc; retire_pc = r.pc; retire_rd = r.rd;
    retire_reg_write = r.wr; retire_data = r.data;
    if (out_valid && rdy) got.push_back(out_data);
    stall = out_valid && !rdy;
    held  = out_data;
    model_step(en && rv, r, rdy);
    @(posedge clk);
    #1;
    check_state();
    if (stall) chk("stall_hold", 32'(out_data), 32'(held));
  endtask

  task automatic drain(input bit rand_rdy);
    for (int i = 0; i < 3000 && (rem > 0 || mq.size() > 0); i++)
      cyc(1'b1, 1'b0, zero_rec, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    cyc(1'b1, 1'b0, zero_rec, 1'b1);
    chk("drained_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; retire_valid = 1'b0; retire_reg_write = 1'b0; out_ready = 1'b0;
    cycle_count = '0; retire_pc = '0; retire_data = '0; retire_rd = '0;
    model_reset();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single retirement: latency and golden byte stream.
    got.delete();
    cyc(1'b1, 1'b1, mk(32'h10, 32'h4, 5'd5, 1'b1, 32'hDEADBEEF), 1'b1);
    chk("lat_level1", 32'(fifo_level), 32'd1);
    chk("lat_valid0", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, zero_rec, 1'b1);
    chk("lat_valid1", 32'(out_valid), 32'd1);
    chk("lat_a5", 32'(out_data), 32'hA5);
    drain(1'b0);
    chk("single_len", 32'(got.size()), 32'd14);
    for (int i = 0; i < 14; i++) chk("golden", 32'(got[i]), 32'(GOLD[i]));

    // rd = 0 forces we and data to zero.
    got.delete();
    cyc(1'b1, 1'b1, mk(32'h20, 32'h8, 5'd0, 1'b1, 32'h1234), 1'b1);
    drain(1'b0);
    chk("rd0_len", 32'(got.size()), 32'd14);
    chk("rd0_hdr", 32'(got[1]), 32'h00);
    for (int i = 10; i < 14; i++) chk("rd0_data", 32'(got[i]), 32'h00);

    // Random back-pressure over three records.
    got.delete();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, rand_rec(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) cyc(1'b1, 1'b0, zero_rec, 1'($urandom_range(0, 1)));
    end
    drain(1'b1);
    chk("rand_len", 32'(got.size()), 32'd42);

    // enable low: no capture while an in-flight packet still completes.
    got.delete();
    cyc(1'b1, 1'b1, rand_rec(), 1'b1);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'($urandom_range(0, 1)), rand_rec(), 1'b1);
    drain(1'b0);
    chk("en0_len", 32'(got.size()), 32'd14);
    chk("en0_drops", 32'(drop_count), 32'd0);

    // Overflow: 11 retirements with the sink stalled.
    got.delete();
    for (int k = 0; k < 11; k++) cyc(1'b1, 1'b1, rand_rec(), 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    chk("ovf_valid", 32'(out_valid), 32'd1);
    drain(1'b0);
    chk("ovf_len", 32'(got.size()), 32'd126);

    // Asynchronous reset while byte 6 is presented, three records queued.
    got.delete();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, rand_rec(), 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, zero_rec, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, zero_rec, 1'b1);
    chk("post_rst_silent", 32'(got.size()), 32'd6);
    cyc(1'b1, 1'b1, rand_rec(), 1'b1);
    drain(1'b0);
    chk("post_rst_len", 32'(got.size()), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
